counter_updn_mod: RTL and testbench

COUNTER_UPDN_MOD -- requirements
Module: counter_updn_mod

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_prescaler.sv | 42 ++++
 rtl/counter_updn_mod.sv | 93 +++++++++
 tb/tb_counter_updn_mod.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Limit a requested load value to the terminal value of the counter.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step-tick generator: emits one tick per PRESCALE enabled cycles.
module counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      // No division needed, so no state is kept.
      logic unused_sig;
      assign unused_sig = &{1'b0, clk, rst, clr};
      assign tick = en;
    end else begin : g_div
      localparam int unsigned PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] cnt;
      logic [PW-1:0] cnt_nxt;

      always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
      end

      always_comb begin
        cnt_nxt = cnt;
        if (clr)
          cnt_nxt = '0;
        else if (en)
          cnt_nxt = (cnt == LAST) ? '0 : cnt + PW'(1);
      end

      assign tick = en && !clr && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/counter_updn_mod.sv
// Prescaled up/down counter with wrap pulse and sticky overflow.
// Optional saturation input sat is compiled in with COUNTER_UPDN_SAT_EN.
module counter_updn_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter logic [31:0] MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
`ifdef COUNTER_UPDN_SAT_EN
  input  logic             sat,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap_p,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_VAL);

  logic             tick;
  logic             sat_mode;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;

`ifdef COUNTER_UPDN_SAT_EN
  assign sat_mode = sat;
`else
  assign sat_mode = 1'b0;
`endif

  // Load freezes and clears the prescaler; en is ignored during load.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en & ~load),
    .clr  (load),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wrap_p <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      count  <= count_nxt;
      wrap_p <= wrap_nxt;
      ovf    <= ovf_nxt;
    end
  end

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    ovf_nxt   = ovf;
    if (load) begin
      count_nxt = WIDTH'(clamp_load(32'(load_val), 32'(MAXC)));
      ovf_nxt   = 1'b0;
    end else if (tick) begin
      if (up_dn == DIR_UP) begin
        if (count == MAXC) begin
          if (!sat_mode) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
            ovf_nxt   = 1'b1;
          end
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          if (!sat_mode) begin
            count_nxt = MAXC;
            wrap_nxt  = 1'b1;
            ovf_nxt   = 1'b1;
          end
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_updn_mod.sv
// Scoreboard bench for counter_updn_mod (WIDTH=4, MAX_VAL=9, PRESCALE 1 and 3).
module tb_counter_updn_mod;

  typedef struct {
    int         idx;
    logic [3:0] c;
    logic       w;
    logic       o;
  } exp_t;

`ifdef COUNTER_UPDN_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] count1, count3;
  logic       wrap1, wrap3, ovf1, ovf3;

  int total = 0;
  int bad = 0;

  exp_t sb[$];

  int   ps[2] = '{1, 3};
  int   m_c[2];
  int   m_p[2];
  logic m_w[2];
  logic m_o[2];

  always #5 clk = ~clk;

  counter_updn_mod #(.WIDTH(4), .MAX_VAL(32'd9), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
`ifdef COUNTER_UPDN_SAT_EN
    .sat(sat),
`endif
    .load(load), .load_val(load_val),
    .count(count1), .wrap_p(wrap1), .ovf(ovf1)
  );

  counter_updn_mod #(.WIDTH(4), .MAX_VAL(32'd9), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
`ifdef COUNTER_UPDN_SAT_EN
    .sat(sat),
`endif
    .load(load), .load_val(load_val),
    .count(count3), .wrap_p(wrap3), .ovf(ovf3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference behaviour of one counter for the inputs of the coming edge.
  task automatic model(input int k, input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] lv, input logic s);
    if (r) begin
      m_c[k] = 0; m_p[k] = 0; m_w[k] = 1'b0; m_o[k] = 1'b0;
    end else if (l) begin
      m_c[k] = (lv > 9) ? 9 : int'(lv);
      m_p[k] = 0; m_w[k] = 1'b0; m_o[k] = 1'b0;
    end else begin
      m_w[k] = 1'b0;
      if (e) begin
        if (m_p[k] == ps[k] - 1) begin
          m_p[k] = 0;
          if (u) begin
            if (m_c[k] < 9) m_c[k]++;
            else if (!(s && SAT_ON)) begin m_c[k] = 0; m_w[k] = 1'b1; m_o[k] = 1'b1; end
          end else begin
            if (m_c[k] > 0) m_c[k]--;
            else if (!(s && SAT_ON)) begin m_c[k] = 9; m_w[k] = 1'b1; m_o[k] = 1'b1; end
          end
        end else begin
          m_p[k]++;
        end
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic u,
                      input logic l, input logic [3:0] lv, input logic s);
    exp_t x;
    rst = r; en = e; up_dn = u; load = l; load_val = lv; sat = s;
    for (int k = 0; k < 2; k++) begin
      model(k, r, e, u, l, lv, s);
      x.idx = k; x.c = 4'(m_c[k]); x.w = m_w[k]; x.o = m_o[k];
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      if (x.idx == 0) begin
        chk({tag, "/p1.count"}, int'(count1), int'(x.c));
        chk({tag, "/p1.wrap_p"}, int'(wrap1), int'(x.w));
        chk({tag, "/p1.ovf"}, int'(ovf1), int'(x.o));
      end else begin
        chk({tag, "/p3.count"}, int'(count3), int'(x.c));
        chk({tag, "/p3.wrap_p"}, int'(wrap3), int'(x.w));
        chk({tag, "/p3.ovf"}, int'(ovf3), int'(x.o));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_c[k] = 0; m_p[k] = 0; m_w[k] = 1'b0; m_o[k] = 1'b0;
    end

    // Reset, then count up through the wrap.
    step("rst0", 1, 0, 1, 0, 4'd0, 0);
    step("rst1", 1, 1, 1, 1, 4'd5, 0);
    chk("reset.count", int'(count1), 0);
    for (int i = 1; i <= 10; i++) begin
      step("up", 0, 1, 1, 0, 4'd0, 0);
      chk("up.seq", int'(count1), i % 10);
    end
    chk("wrap.pulse", int'(wrap1), 1);
    chk("wrap.ovf", int'(ovf1), 1);
    step("after_wrap", 0, 1, 1, 0, 4'd0, 0);
    chk("wrap.one_cycle", int'(wrap1), 0);

    // Down-count underflow, then clamped load.
    step("ld0", 0, 0, 0, 1, 4'd0, 0);
    step("dn", 0, 1, 0, 0, 4'd0, 0);
    chk("under.count", int'(count1), 9);
    chk("under.wrap", int'(wrap1), 1);
    chk("under.ovf", int'(ovf1), 1);
    step("ld15", 0, 0, 0, 1, 4'd15, 0);
    chk("clamp.count", int'(count1), 9);
    chk("clamp.ovf", int'(ovf1), 0);

    // Prescale 3: steady stepping, en gap mid-prescale, direction change.
    step("ld_p", 0, 0, 1, 1, 4'd0, 0);
    for (int i = 0; i < 7; i++) step("pre", 0, 1, 1, 0, 4'd0, 0);
    chk("pre.count3", int'(count3), 2);
    step("gap", 0, 0, 1, 0, 4'd0, 0);
    step("gap", 0, 0, 1, 0, 4'd0, 0);
    step("pre2", 0, 1, 1, 0, 4'd0, 0);
    chk("pre.stretch", int'(count3), 2);
    step("pre2", 0, 1, 1, 0, 4'd0, 0);
    chk("pre.stretch_tick", int'(count3), 3);
    step("dir", 0, 1, 0, 0, 4'd0, 0);
    step("dir", 0, 1, 0, 0, 4'd0, 0);
    step("dir", 0, 1, 0, 0, 4'd0, 0);
    chk("pre.dir", int'(count3), 2);

    // Load beats counting; reset beats load; reset drops partial prescale.
    step("ld9", 0, 0, 1, 1, 4'd9, 0);
    step("ld_en", 0, 1, 1, 1, 4'd3, 0);
    chk("ld_en.count", int'(count1), 3);
    chk("ld_en.wrap", int'(wrap1), 0);
    step("pp", 0, 1, 1, 0, 4'd0, 0);
    step("rst_ld", 1, 1, 1, 1, 4'd7, 0);
    chk("rst_ld.count", int'(count1), 0);
    step("post_rst", 0, 1, 1, 0, 4'd0, 0);
    step("post_rst", 0, 1, 1, 0, 4'd0, 0);
    chk("post_rst.hold3", int'(count3), 0);
    step("post_rst", 0, 1, 1, 0, 4'd0, 0);
    chk("post_rst.tick3", int'(count3), 1);

`ifdef COUNTER_UPDN_SAT_EN
    step("sat_ld", 0, 0, 1, 1, 4'd9, 0);
    for (int i = 0; i < 3; i++) step("sat", 0, 1, 1, 0, 4'd0, 1);
    chk("sat.count", int'(count1), 9);
    chk("sat.wrap", int'(wrap1), 0);
    chk("sat.ovf", int'(ovf1), 0);
    step("nosat", 0, 1, 1, 0, 4'd0, 0);
    chk("nosat.count", int'(count1), 0);
    chk("nosat.wrap", int'(wrap1), 1);
`endif

    // Mixed random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
